id_ex_pipeline_register: RTL and testbench

// - ID/EX stage boundary of the PPU pipeline. Latches the 18-bit control bundle from PPU_Control_Unit with the ID operands.
// - Detects load-use hazards against the instruction currently in EX. On a hazard it inserts a bubble and stalls PC and IF/ID.
// - Supports a flush for taken branches/jumps, and a hold from the memory stage. Counts inserted bubbles for performance debug.

---
 rtl/ppu_ctrl_pkg.sv | 55 +++++
 rtl/load_use_hazard_detector.sv | 21 ++
 rtl/id_ex_pipeline_register.sv | 85 ++++++++
 tb/tb_id_ex_pipeline_register.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_ctrl_pkg.sv
// Shared PPU control-bundle definitions: bit positions of the 18-bit ID/EX control
// bundle, the NOP bundle, and the opcode/funct constants used by the control unit.
package ppu_ctrl_pkg;

    localparam int CTRL_BITS = 18;

    localparam int CTRL_SRC_OP_MSB   = 17;
    localparam int CTRL_SRC_OP_LSB   = 15;
    localparam int CTRL_ALU_OP_MSB   = 14;
    localparam int CTRL_ALU_OP_LSB   = 11;
    localparam int CTRL_LOAD         = 10;
    localparam int CTRL_RF_EN        = 9;
    localparam int CTRL_B_INSTR      = 8;
    localparam int CTRL_TA_INSTR     = 7;
    localparam int CTRL_MEM_SIZE_MSB = 6;
    localparam int CTRL_MEM_SIZE_LSB = 5;
    localparam int CTRL_MEM_RW       = 4;
    localparam int CTRL_MEM_SE       = 3;
    localparam int CTRL_MEM_EN       = 2;
    localparam int CTRL_HI_EN        = 1;
    localparam int CTRL_LO_EN        = 0;

    // All enables low: a bubble built from this has no architectural side effects.
    localparam logic [CTRL_BITS-1:0] CTRL_NOP = 18'b0;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2a;

endpackage

// File: rtl/load_use_hazard_detector.sv
// Purely combinational load-use check: a register-writing load in EX whose
// destination is read by the valid ID instruction. $0 never creates a dependency.
module load_use_hazard_detector (
    input  logic       ex_valid,
    input  logic       ex_load,
    input  logic       ex_rf_en,
    input  logic [4:0] ex_dest_addr,
    input  logic       id_valid,
    input  logic [4:0] id_rs_addr,
    input  logic [4:0] id_rt_addr,
    output logic       hazard
);

    logic ex_is_load_wr;
    logic src_match;

    assign ex_is_load_wr = ex_valid & ex_load & ex_rf_en & (ex_dest_addr != 5'd0);
    assign src_match     = (ex_dest_addr == id_rs_addr) | (ex_dest_addr == id_rt_addr);
    assign hazard        = ex_is_load_wr & id_valid & src_match;

endmodule

// File: rtl/id_ex_pipeline_register.sv
// ID/EX boundary register of the PPU pipeline with load-use bubble insertion,
// branch flush, memory-stage hold and a saturating bubble counter.
module id_ex_pipeline_register
    import ppu_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 18,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_rs_val,
    input  logic [DATA_W-1:0] id_rt_val,
    input  logic [15:0]       id_imm16,
    input  logic [4:0]        id_rs_addr,
    input  logic [4:0]        id_rt_addr,
    input  logic [4:0]        id_dest_addr,
    input  logic              flush,
    input  logic              mem_hold,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_rs_val,
    output logic [DATA_W-1:0] ex_rt_val,
    output logic [15:0]       ex_imm16,
    output logic [4:0]        ex_dest_addr,
    output logic              hazard_stall,
    output logic [CNT_W-1:0]  bubble_count
);

    logic hazard;

    load_use_hazard_detector u_hazard (
        .ex_valid     (ex_valid),
        .ex_load      (ex_ctrl[CTRL_LOAD]),
        .ex_rf_en     (ex_ctrl[CTRL_RF_EN]),
        .ex_dest_addr (ex_dest_addr),
        .id_valid     (id_valid),
        .id_rs_addr   (id_rs_addr),
        .id_rt_addr   (id_rt_addr),
        .hazard       (hazard)
    );

    // A flushed instruction must not stall the front end it is being killed from.
    assign hazard_stall = hazard & ~flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid     <= 1'b0;
            ex_ctrl      <= CTRL_NOP;
            ex_pc        <= '0;
            ex_rs_val    <= '0;
            ex_rt_val    <= '0;
            ex_imm16     <= '0;
            ex_dest_addr <= '0;
            bubble_count <= '0;
        end else if (flush) begin
            ex_valid     <= 1'b0;
            ex_ctrl      <= CTRL_NOP;
            ex_dest_addr <= '0;
        end else if (mem_hold) begin
            ex_valid     <= ex_valid;
        end else if (hazard) begin
            // Data fields are left as-is: the bubble's zero control makes them inert.
            ex_valid     <= 1'b0;
            ex_ctrl      <= CTRL_NOP;
            ex_dest_addr <= '0;
            if (~&bubble_count) begin
                bubble_count <= bubble_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            ex_valid     <= id_valid;
            ex_ctrl      <= id_valid ? id_ctrl : CTRL_NOP;
            ex_pc        <= id_pc;
            ex_rs_val    <= id_rs_val;
            ex_rt_val    <= id_rt_val;
            ex_imm16     <= id_imm16;
            ex_dest_addr <= id_dest_addr;
        end
    end

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// Self-checking bench for id_ex_pipeline_register: directed vector table, hand
// sequences for hold/saturation/reset, and randomized traffic against a reference model.
module tb_id_ex_pipeline_register;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 18;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              id_valid;
    logic [CTRL_W-1:0] id_ctrl;
    logic [DATA_W-1:0] id_pc, id_rs_val, id_rt_val;
    logic [15:0]       id_imm16;
    logic [4:0]        id_rs_addr, id_rt_addr, id_dest_addr;
    logic              flush, mem_hold;
    logic              ex_valid;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [DATA_W-1:0] ex_pc, ex_rs_val, ex_rt_val;
    logic [15:0]       ex_imm16;
    logic [4:0]        ex_dest_addr;
    logic              hazard_stall;
    logic [CNT_W-1:0]  bubble_count;

    id_ex_pipeline_register #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_pc(id_pc), .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm16(id_imm16),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_dest_addr(id_dest_addr),
        .flush(flush), .mem_hold(mem_hold), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
        .ex_pc(ex_pc), .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val), .ex_imm16(ex_imm16),
        .ex_dest_addr(ex_dest_addr), .hazard_stall(hazard_stall), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: what EX should hold, tracked as plain state.
    logic        m_valid;
    logic [17:0] m_ctrl;
    logic [31:0] m_pc, m_rs, m_rt;
    logic [15:0] m_imm;
    logic [4:0]  m_dest;
    int          m_cnt;
    bit          m_data_ok;

    function automatic bit m_hazard();
        bit ex_load_writes;
        bit reads_it;
        ex_load_writes = m_valid && m_ctrl[10] && m_ctrl[9] && (m_dest != 0);
        reads_it = (m_dest == id_rs_addr) || (m_dest == id_rt_addr);
        return ex_load_writes && id_valid && reads_it;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_ctrl = 0; m_pc = 0; m_rs = 0; m_rt = 0; m_imm = 0; m_dest = 0;
        m_cnt = 0; m_data_ok = 1;
    endtask

    task automatic model_bubble();
        m_valid = 0; m_ctrl = 0; m_dest = 0; m_data_ok = 0;
    endtask

    task automatic model_next();
        if (flush) model_bubble();
        else if (mem_hold) begin end
        else if (m_hazard()) begin
            model_bubble();
            if (m_cnt < CMAX) m_cnt++;
        end else begin
            m_valid = id_valid;
            m_ctrl  = id_valid ? id_ctrl : 18'h0;
            m_pc = id_pc; m_rs = id_rs_val; m_rt = id_rt_val; m_imm = id_imm16;
            m_dest = id_dest_addr; m_data_ok = 1;
        end
    endtask

    task automatic tick();
        model_next();
        @(posedge clk);
        #1;
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".ex_valid"}, 64'(ex_valid), 64'(m_valid));
        check({tag, ".ex_ctrl"}, 64'(ex_ctrl), 64'(m_ctrl));
        check({tag, ".ex_dest"}, 64'(ex_dest_addr), 64'(m_dest));
        check({tag, ".count"}, 64'(bubble_count), 64'(m_cnt));
        if (m_data_ok) begin
            check({tag, ".ex_pc"}, 64'(ex_pc), 64'(m_pc));
            check({tag, ".ex_rs"}, 64'(ex_rs_val), 64'(m_rs));
            check({tag, ".ex_rt"}, 64'(ex_rt_val), 64'(m_rt));
            check({tag, ".ex_imm"}, 64'(ex_imm16), 64'(m_imm));
        end
    endtask

    task automatic drive(input logic v, input logic [17:0] c, input logic [31:0] pc,
                         input logic [4:0] rsa, input logic [4:0] rta, input logic [4:0] dst,
                         input logic fl, input logic hd);
        id_valid = v; id_ctrl = c; id_pc = pc;
        id_rs_val = pc ^ 32'hA5A5_0000; id_rt_val = ~pc; id_imm16 = pc[15:0] + 16'd3;
        id_rs_addr = rsa; id_rt_addr = rta; id_dest_addr = dst;
        flush = fl; mem_hold = hd;
    endtask

    typedef struct {
        logic        iv;
        logic [17:0] ictrl;
        logic [31:0] ipc;
        logic [4:0]  irsa, irta, idest;
        logic        fl, hd;
        logic        e_hs, e_v;
        logic [17:0] e_ctrl;
        logic [31:0] e_pc;
        logic        chk_pc;
        logic [4:0]  e_dest;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t tbl[17];

    initial begin
        tbl[0]  = '{1, 18'h04800, 32'h10, 1, 2, 3, 0, 0, 0, 1, 18'h04800, 32'h10, 1, 3, 0};
        tbl[1]  = '{1, 18'h00604, 32'h14, 4, 8, 8, 0, 0, 0, 1, 18'h00604, 32'h14, 1, 8, 0};
        tbl[2]  = '{1, 18'h04800, 32'h18, 8, 0, 9, 0, 0, 1, 0, 18'h0, 32'h0, 0, 0, 1};
        tbl[3]  = '{1, 18'h04800, 32'h18, 8, 0, 9, 0, 0, 0, 1, 18'h04800, 32'h18, 1, 9, 1};
        tbl[4]  = '{1, 18'h00604, 32'h1c, 1, 2, 0, 0, 0, 0, 1, 18'h00604, 32'h1c, 1, 0, 1};
        tbl[5]  = '{1, 18'h04800, 32'h20, 0, 0, 5, 0, 0, 0, 1, 18'h04800, 32'h20, 1, 5, 1};
        tbl[6]  = '{1, 18'h00604, 32'h24, 5, 7, 6, 0, 0, 0, 1, 18'h00604, 32'h24, 1, 6, 1};
        tbl[7]  = '{1, 18'h04800, 32'h28, 6, 1, 7, 1, 1, 0, 0, 18'h0, 32'h0, 0, 0, 1};
        tbl[8]  = '{0, 18'h04800, 32'h2c, 1, 1, 4, 0, 0, 0, 0, 18'h0, 32'h2c, 1, 4, 1};
        tbl[9]  = '{1, 18'h00604, 32'h30, 0, 0, 10, 0, 0, 0, 1, 18'h00604, 32'h30, 1, 10, 1};
        tbl[10] = '{1, 18'h04800, 32'h34, 3, 10, 11, 0, 1, 1, 1, 18'h00604, 32'h30, 1, 10, 1};
        tbl[11] = '{1, 18'h04800, 32'h34, 3, 10, 11, 0, 0, 1, 0, 18'h0, 32'h0, 0, 0, 2};
        tbl[12] = '{1, 18'h04800, 32'h34, 3, 10, 11, 0, 0, 0, 1, 18'h04800, 32'h34, 1, 11, 2};
        tbl[13] = '{1, 18'h00404, 32'h38, 1, 2, 12, 0, 0, 0, 1, 18'h00404, 32'h38, 1, 12, 2};
        tbl[14] = '{1, 18'h04800, 32'h3c, 12, 0, 13, 0, 0, 0, 1, 18'h04800, 32'h3c, 1, 13, 2};
        tbl[15] = '{1, 18'h00604, 32'h40, 0, 0, 14, 0, 0, 0, 1, 18'h00604, 32'h40, 1, 14, 2};
        tbl[16] = '{0, 18'h04800, 32'h44, 14, 0, 15, 0, 0, 0, 0, 18'h0, 32'h44, 1, 15, 2};

        reset_n = 1'b0;
        drive(0, 18'h0, 32'h0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        check("rst.ex_valid", 64'(ex_valid), 0);
        check("rst.ex_ctrl", 64'(ex_ctrl), 0);
        check("rst.ex_pc", 64'(ex_pc), 0);
        check("rst.count", 64'(bubble_count), 0);
        check("rst.stall", 64'(hazard_stall), 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].iv, tbl[i].ictrl, tbl[i].ipc, tbl[i].irsa, tbl[i].irta,
                  tbl[i].idest, tbl[i].fl, tbl[i].hd);
            #1;
            check($sformatf("vec%0d.stall", i), 64'(hazard_stall), 64'(tbl[i].e_hs));
            tick();
            check($sformatf("vec%0d.ex_valid", i), 64'(ex_valid), 64'(tbl[i].e_v));
            check($sformatf("vec%0d.ex_ctrl", i), 64'(ex_ctrl), 64'(tbl[i].e_ctrl));
            check($sformatf("vec%0d.ex_dest", i), 64'(ex_dest_addr), 64'(tbl[i].e_dest));
            check($sformatf("vec%0d.count", i), 64'(bubble_count), 64'(tbl[i].e_cnt));
            if (tbl[i].chk_pc)
                check($sformatf("vec%0d.ex_pc", i), 64'(ex_pc), 64'(tbl[i].e_pc));
        end

        // Hold for three cycles with a changing ID stage, then release.
        drive(1, 18'h04800, 32'h100, 1, 2, 3, 0, 0);
        tick();
        compare_model("prehold");
        for (int i = 0; i < 3; i++) begin
            drive(1, 18'h05A00 + 18'(i), 32'h200 + 32'(i * 4), 5'(i), 5'(i + 1), 5'(i + 20), 0, 1);
            tick();
            check($sformatf("hold%0d.ex_pc", i), 64'(ex_pc), 64'h100);
            check($sformatf("hold%0d.ex_ctrl", i), 64'(ex_ctrl), 64'h04800);
        end
        drive(1, 18'h04800, 32'h300, 1, 2, 3, 0, 0);
        tick();
        check("release.ex_pc", 64'(ex_pc), 64'h300);
        compare_model("release");

        // A load whose consumer is itself: one bubble every two cycles until saturation.
        drive(1, 18'h00604, 32'h400, 8, 8, 8, 0, 0);
        for (int i = 0; i < 40; i++) begin
            #1;
            check("sat.stall", 64'(hazard_stall), 64'(m_hazard()));
            tick();
            compare_model("sat");
        end
        check("sat.count", 64'(bubble_count), 64'(CMAX));

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [17:0] c;
            c = 18'($urandom);
            if ($urandom_range(0, 1) == 0) c = c | 18'h00600;
            drive($urandom_range(0, 7) != 0, c, $urandom,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
            #1;
            check("rnd.stall", 64'(hazard_stall), 64'(m_hazard() && !flush));
            tick();
            compare_model("rnd");
        end

        // Asynchronous reset between edges, then first edge after release loads ID.
        drive(1, 18'h00604, 32'h500, 1, 2, 9, 0, 0);
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("arst.ex_valid", 64'(ex_valid), 0);
        check("arst.ex_ctrl", 64'(ex_ctrl), 0);
        check("arst.ex_pc", 64'(ex_pc), 0);
        check("arst.ex_dest", 64'(ex_dest_addr), 0);
        check("arst.count", 64'(bubble_count), 0);
        #1;
        reset_n = 1'b1;
        drive(1, 18'h04800, 32'h99, 1, 2, 7, 0, 0);
        tick();
        check("postrst.ex_pc", 64'(ex_pc), 64'h99);
        check("postrst.ex_valid", 64'(ex_valid), 1);
        compare_model("postrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
